load_store_unit: RTL and testbench

- Initiator side of the word-organised data RAM interface (`we`, byte `addr`, `din`, combinational `dout`).
- Sits in the MEM stage of the RV32IM pipeline and executes LB/LH/LW/LBU/LHU/SB/SH/SW.
- The RAM only writes whole words, so SB/SH are done as a two-cycle read-modify-write.
- Returns sign/zero-extended load data and flags misaligned, illegal or out-of-range accesses without touching memory.

---
 rtl/load_store_unit_pkg.sv | 30 +++
 rtl/lsu_align.sv | 64 ++++++
 rtl/load_store_unit.sv | 113 +++++++++++
 tb/tb_load_store_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and
// request legality helpers used at accept time.
package load_store_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        STORE  = 3'd2,
        RMW_RD = 3'd3,
        RMW_WR = 3'd4,
        RESP   = 3'd5
    } state_t;

    // 011/11x are never legal; unsigned sizes make no sense for stores.
    function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
        return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
    endfunction

    // Halves need addr[0]=0, words need addr[1:0]=0.
    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        return ((f3 == F3_H || f3 == F3_HU) && lo[0]) || ((f3 == F3_W) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering between a RAM word and the pipeline.
// Ports: funct3/addr_lo select the lane; mem_word is the RAM word; wdata is
// store data. load_data_c is the extended load result, store_word_c is
// mem_word with the store lane(s) replaced (or wdata for a full word).
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] mem_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data_c,
    output logic [31:0] store_word_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane selection for loads.
    always_comb begin
        byte_sel = mem_word[7:0];
        case (addr_lo)
            2'd1:    byte_sel = mem_word[15:8];
            2'd2:    byte_sel = mem_word[23:16];
            2'd3:    byte_sel = mem_word[31:24];
            default: byte_sel = mem_word[7:0];
        endcase
        half_sel = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
    end

    // Sign/zero extension of the selected lane.
    always_comb begin
        case (funct3)
            F3_B:    load_data_c = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_data_c = {24'd0, byte_sel};
            F3_H:    load_data_c = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_data_c = {16'd0, half_sel};
            default: load_data_c = mem_word;
        endcase
    end

    // Merge of store data into the word read back from RAM.
    always_comb begin
        store_word_c = wdata;
        case (funct3)
            F3_B: begin
                store_word_c = mem_word;
                case (addr_lo)
                    2'd1:    store_word_c[15:8]  = wdata[7:0];
                    2'd2:    store_word_c[23:16] = wdata[7:0];
                    2'd3:    store_word_c[31:24] = wdata[7:0];
                    default: store_word_c[7:0]   = wdata[7:0];
                endcase
            end
            F3_H: begin
                store_word_c = mem_word;
                if (addr_lo[1]) store_word_c[31:16] = wdata[15:0];
                else            store_word_c[15:0]  = wdata[15:0];
            end
            default: store_word_c = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit driving a word-organised RAM.
// Ports: req_* is the pipeline request (valid/ready handshake), resp_* the
// one-cycle completion (data, error), mem_* the RAM initiator interface with
// combinational read data mem_dout. Sub-word stores are read-modify-write.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned MEM_WORDS   = 256,
    parameter int unsigned CHECK_RANGE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    localparam int unsigned MEM_BYTES = MEM_WORDS * 4;

    state_t      state;
    logic [31:0] addr_q;
    logic [31:0] data_q;   // store data, replaced by the merged word in RMW_RD
    logic [2:0]  f3_q;
    logic        range_err_c;
    logic        req_err_c;
    logic [31:0] load_data_c;
    logic [31:0] store_word_c;

    // Full 33-bit compare so high addresses cannot alias into the RAM.
    assign range_err_c = (CHECK_RANGE != 0) && ({1'b0, req_addr} >= 33'(MEM_BYTES));
    assign req_err_c   = range_err_c
                       || f3_illegal(req_funct3, req_we)
                       || f3_misaligned(req_funct3, req_addr[1:0]);

    assign req_ready = (state == IDLE);
    assign mem_we    = ((state == STORE) || (state == RMW_WR)) && !rst;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_din   = data_q;

    lsu_align u_align (
        .funct3       (f3_q),
        .addr_lo      (addr_q[1:0]),
        .mem_word     (mem_dout),
        .wdata        (data_q),
        .load_data_c  (load_data_c),
        .store_word_c (store_word_c)
    );

    // The response is registered on the edge leaving the last busy state, so
    // it is visible while the FSM is already back in IDLE and can accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            f3_q       <= 3'd0;
        end else begin
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q <= req_addr;
                        data_q <= req_wdata;
                        f3_q   <= req_funct3;
                        if (req_err_c)              state <= RESP;
                        else if (!req_we)           state <= LOAD;
                        else if (req_funct3 == F3_W) state <= STORE;
                        else                        state <= RMW_RD;
                    end
                end
                LOAD: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= load_data_c;
                    state      <= IDLE;
                end
                STORE: begin
                    resp_valid <= 1'b1;
                    state      <= IDLE;
                end
                RMW_RD: begin
                    data_q <= store_word_c;
                    state  <= RMW_WR;
                end
                RMW_WR: begin
                    resp_valid <= 1'b1;
                    state      <= IDLE;
                end
                RESP: begin
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 256-word RAM.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    int total = 0;
    int bad   = 0;

    logic [31:0] ram [0:255];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr[9:2]] <= mem_din;
    end
    assign mem_dout = ram[mem_addr[9:2]];

    load_store_unit #(.MEM_WORDS(256), .CHECK_RANGE(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One isolated op: present it, accept, then watch six cycles.
    // Cycle k=1 is the cycle right after the accept edge.
    task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int exp_lat, input int exp_we_cyc, input logic [31:0] exp_din);
        int          resp_cyc;
        int          we_n;
        int          we_cyc;
        logic [31:0] din_seen;
        logic [31:0] got_rdata;
        logic        got_err;
        resp_cyc = 0; we_n = 0; we_cyc = 0;
        din_seen = 32'd0; got_rdata = 32'd0; got_err = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        chk({tag, ".ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (mem_we) begin
                we_n++;
                we_cyc   = k;
                din_seen = mem_din;
            end
            if (resp_valid && resp_cyc == 0) begin
                resp_cyc  = k;
                got_rdata = resp_rdata;
                got_err   = resp_err;
            end
        end
        chk({tag, ".lat"},   32'(resp_cyc), 32'(exp_lat));
        chk({tag, ".rdata"}, got_rdata, exp_rdata);
        chk({tag, ".err"},   32'(got_err), 32'(exp_err));
        chk({tag, ".we_n"},  32'(we_n), (exp_we_cyc == 0) ? 32'd0 : 32'd1);
        chk({tag, ".we_cyc"}, 32'(we_cyc), 32'(exp_we_cyc));
        if (exp_we_cyc != 0) chk({tag, ".din"}, din_seen, exp_din);
    endtask

    logic        hs_we    [3];
    logic [2:0]  hs_f3    [3];
    logic [31:0] hs_addr  [3];
    logic [31:0] hs_wdata [3];
    logic [31:0] hs_got   [3];
    int          idx, nresp, coincide;
    logic        busy_seen, will_acc;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0;
        req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("rst.resp_rdata", resp_rdata, 32'd0);
        chk("rst.resp_err",   32'(resp_err), 32'd0);
        chk("rst.ready",      32'(req_ready), 32'd1);
        chk("rst.mem_we",     32'(mem_we), 32'd0);

        // Full word
        run_op("sw10", 1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'd0, 1'b0, 2, 1, 32'hDEADBEEF);
        run_op("lw10", 1'b0, F3_W, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 2, 0, 32'd0);

        // Sub-word loads
        run_op("sw20", 1'b1, F3_W, 32'h20, 32'h80FF7F01, 32'd0, 1'b0, 2, 1, 32'h80FF7F01);
        run_op("lb23",  1'b0, F3_B,  32'h23, 32'd0, 32'hFFFFFF80, 1'b0, 2, 0, 32'd0);
        run_op("lbu23", 1'b0, F3_BU, 32'h23, 32'd0, 32'h00000080, 1'b0, 2, 0, 32'd0);
        run_op("lh22",  1'b0, F3_H,  32'h22, 32'd0, 32'hFFFF80FF, 1'b0, 2, 0, 32'd0);
        run_op("lhu20", 1'b0, F3_HU, 32'h20, 32'd0, 32'h00007F01, 1'b0, 2, 0, 32'd0);
        run_op("lb20",  1'b0, F3_B,  32'h20, 32'd0, 32'h00000001, 1'b0, 2, 0, 32'd0);

        // Read-modify-write
        run_op("sw30", 1'b1, F3_W, 32'h30, 32'h11223344, 32'd0, 1'b0, 2, 1, 32'h11223344);
        run_op("sb31", 1'b1, F3_B, 32'h31, 32'h123456AA, 32'd0, 1'b0, 3, 2, 32'h1122AA44);
        run_op("lw30a", 1'b0, F3_W, 32'h30, 32'd0, 32'h1122AA44, 1'b0, 2, 0, 32'd0);
        run_op("sh32", 1'b1, F3_H, 32'h32, 32'h0000BEEF, 32'd0, 1'b0, 3, 2, 32'hBEEFAA44);
        run_op("lw30b", 1'b0, F3_W, 32'h30, 32'd0, 32'hBEEFAA44, 1'b0, 2, 0, 32'd0);

        // Errors and range boundary
        run_op("e_lw02",  1'b0, F3_W,  32'h02, 32'd0, 32'd0, 1'b1, 2, 0, 32'd0);
        run_op("e_sh05",  1'b1, F3_H,  32'h05, 32'hFFFF, 32'd0, 1'b1, 2, 0, 32'd0);
        run_op("e_f3011", 1'b0, 3'b011, 32'h10, 32'd0, 32'd0, 1'b1, 2, 0, 32'd0);
        run_op("e_sbu",   1'b1, F3_BU, 32'h10, 32'h99, 32'd0, 1'b1, 2, 0, 32'd0);
        run_op("e_lw400", 1'b0, F3_W,  32'h400, 32'd0, 32'd0, 1'b1, 2, 0, 32'd0);
        run_op("e_wrap",  1'b0, F3_W,  32'h80000010, 32'd0, 32'd0, 1'b1, 2, 0, 32'd0);
        run_op("sw3fc", 1'b1, F3_W, 32'h3FC, 32'hCAFEF00D, 32'd0, 1'b0, 2, 1, 32'hCAFEF00D);
        run_op("lw3fc", 1'b0, F3_W, 32'h3FC, 32'd0, 32'hCAFEF00D, 1'b0, 2, 0, 32'd0);
        run_op("lw10b", 1'b0, F3_W, 32'h10, 32'd0, 32'hDEADBEEF, 1'b0, 2, 0, 32'd0);

        // Back-to-back LW / SB / LW with req_valid held
        hs_we[0] = 1'b0; hs_f3[0] = F3_W; hs_addr[0] = 32'h10; hs_wdata[0] = 32'd0;
        hs_we[1] = 1'b1; hs_f3[1] = F3_B; hs_addr[1] = 32'h11; hs_wdata[1] = 32'h55;
        hs_we[2] = 1'b0; hs_f3[2] = F3_W; hs_addr[2] = 32'h10; hs_wdata[2] = 32'd0;
        for (int i = 0; i < 3; i++) hs_got[i] = 32'hX;
        idx = 0; nresp = 0; coincide = 0; busy_seen = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = hs_we[0]; req_funct3 = hs_f3[0];
        req_addr = hs_addr[0]; req_wdata = hs_wdata[0];
        for (int c = 0; c < 30 && nresp < 3; c++) begin
            if (c > 0) @(negedge clk);
            if (!req_ready) busy_seen = 1'b1;
            will_acc = req_valid && req_ready;
            if (resp_valid) begin
                hs_got[nresp] = resp_rdata;
                if (will_acc) coincide++;
                nresp++;
            end
            @(posedge clk);
            #1;
            if (will_acc) begin
                idx++;
                if (idx < 3) begin
                    req_we = hs_we[idx]; req_funct3 = hs_f3[idx];
                    req_addr = hs_addr[idx]; req_wdata = hs_wdata[idx];
                end else begin
                    req_valid = 1'b0;
                end
            end
        end
        req_valid = 1'b0;
        chk("hs.accepts",  32'(idx), 32'd3);
        chk("hs.nresp",    32'(nresp), 32'd3);
        chk("hs.busy",     32'(busy_seen), 32'd1);
        chk("hs.coincide", 32'(coincide), 32'd2);
        chk("hs.r0", hs_got[0], 32'hDEADBEEF);
        chk("hs.r1", hs_got[1], 32'h00000000);
        chk("hs.r2", hs_got[2], 32'hDEAD55EF);
        repeat (3) @(negedge clk);

        // Reset during RMW_WR of an SB
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B; req_addr = 32'h30; req_wdata = 32'h77;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rstmid.mem_we", 32'(mem_we), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rstmid.ready",      32'(req_ready), 32'd1);
        chk("rstmid.resp_valid", 32'(resp_valid), 32'd0);
        chk("rstmid.resp_rdata", resp_rdata, 32'd0);
        chk("rstmid.resp_err",   32'(resp_err), 32'd0);
        chk("rstmid.mem_we2",    32'(mem_we), 32'd0);
        run_op("lw30c", 1'b0, F3_W, 32'h30, 32'd0, 32'hBEEFAA44, 1'b0, 2, 0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
